ttc_stream_gen: RTL and testbench
=================================

Name: ttc_stream_gen

Overview:
Parametrised serial TTC frame generator, driving a NRZ bit stream into the ttc_* deserialiser blocks under test.
- Frames are FRAME_W bits, sent MSB first, back-to-back with no gap.
- Each word is repeated REPEAT times, then the next word is taken from a selectable source: sequence counter, external handshake, or rotate.
- Provides a frame-start strobe, frame counter and underrun flag so benches and emulation top-levels can check deserialiser lock and data.

Parameters:
- FRAME_W, 16, bits per frame (data portion).
- REPEAT, 16, consecutive frames each word is sent (>=1).
- INIT_WORD, 16'h817E, first word after leaving IDLE.
- SEQ_INIT, 16'hF0F0, reset value of the sequence register (mode 0).
- IDLE_WORD, 16'hAAAA, word sent on mode-1 underrun.
- CNT_W, 16, width of frame_count.

Ports:
- clksend  in  1  bit clock, all logic on rising edge.
- rstin  in  1  asynchronous, active-high reset.
- enable  in  1  run request.
- mode  in  2  word source: 0 sequence, 1 external, 2 rotate, 3 = same as 0.
- word_in  in  FRAME_W  external word (mode 1).
- word_valid  in  1  word_in valid.
- word_ready  out  1  generator accepts word_in this cycle.
- serial_out  out  1  serial data, registered.
- frame_start  out  1  high during the first bit of every frame.
- frame_count  out  CNT_W  frames started, wraps modulo 2^CNT_W.
- underrun  out  1  one-cycle pulse on mode-1 starvation.

Behaviour:
- Reset (async):
  - State=IDLE; serial_out, frame_start, word_ready, underrun = 0.
  - frame_count=0; bit_cnt=0; rep_cnt=0; seq=SEQ_INIT; current word=INIT_WORD.
- States IDLE and RUN.
- IDLE:
  - serial_out=0, frame_start=0.
  - On an edge where enable=1: go to RUN on that edge.
  - Same edge: serial_out<=INIT_WORD[MSB], frame_start<=1, shift reg<=INIT_WORD<<1, bit_cnt<=0, rep_cnt<=0, frame_count+1.
  - Latency: first bit visible 1 cycle after enable is sampled.
- RUN, each edge:
  - bit_cnt+1; serial_out<=shreg[MSB]; shreg<<=1; frame_start<=0.
  - Frame end is the edge where bit_cnt==FRAME_W-1, i.e. the last bit is currently on serial_out.
- At frame end:
  - If enable=0: go to IDLE, serial_out<=0. The current frame always completes; no truncation.
  - Else start the next frame on the same edge, no gap: frame_start<=1, frame_count+1, bit_cnt<=0.
  - Word selection:
    - rep_cnt<REPEAT-1: rep_cnt+1, same word.
    - Otherwise rep_cnt<=0 and a new word by mode, with mode sampled only at frame end:
      - mode 0/3: word<=seq; seq<=seq+1 (mod 2^FRAME_W).
      - mode 2: word<=current word rotated left 1.
      - mode 1: see handshake below.
- Mode-1 handshake:
  - word_ready is combinational-high only on the frame-end edge that selects a new word with mode==1.
  - Transfer happens when word_valid & word_ready: word<=word_in.
  - If word_valid=0: word<=IDLE_WORD and underrun pulses 1 cycle (registered, coincident with frame_start).
  - word_in is never latched outside word_ready.
- REPEAT=1: new word every frame.
- enable and mode changes mid-frame have no effect until frame end.
- rstin mid-frame: outputs return to reset values immediately.
- frame_count wraps from all-ones to 0 silently.

Optional Feature:
- Macro TTC_GEN_PARITY_EN.
- Defined:
  - One extra bit period is appended after the FRAME_W data bits, carrying even parity (XOR of the word), so frame length = FRAME_W+1 cycles.
  - Frame end moves to bit_cnt==FRAME_W.
  - word_ready, underrun and frame_start timing shift accordingly.
- Undefined: frames are exactly FRAME_W cycles and no parity logic is present.

Test Plan:
- Reset, enable=1, mode=0:
  - serial_out is 1000000101111110 repeated 16 frames.
  - frame_start every 16 cycles.
  - Frame 17 = F0F0 x16, frame 33 = F0F1.
  - frame_count=33 at the start of frame 33.
- mode=1, word_valid held 1, word_in=16'h1234: one word_ready pulse at the last bit of frame 16; frames 17-32 = 0x1234; no underrun.
- mode=1, word_valid=0: underrun pulse coincident with frame_start of frame 17; frames 17-32 = 0xAAAA.
- mode=2: frames 1-16 = 817E, frames 17-32 = 02FD, frames 33-48 = 05FA.
- enable dropped at bit 5 of a frame: remaining 10 bits are sent, then serial_out=0 and no further frame_start. A separate run asserts rstin at bit 7: serial_out=0 and frame_count=0 immediately.
- With TTC_GEN_PARITY_EN: frames are 17 cycles; parity bit 0 for 817E (8 ones) and 0 for F0F0; F0F1 gives parity 1.

Source files
------------

// File: rtl/ttc_stream_gen.sv
// ttc_stream_gen: serial TTC frame generator, NRZ, MSB first, back-to-back frames
// Ports: clksend/rstin (async, active-high) clock and reset; enable run request;
//   mode word source (0/3 sequence, 1 external handshake, 2 rotate);
//   word_in/word_valid/word_ready external word handshake; serial_out bit stream;
//   frame_start first-bit strobe; frame_count frames started; underrun mode-1 starvation pulse.
// Build option: define TTC_GEN_PARITY_EN to append an even-parity bit to every frame.
module ttc_stream_gen #(
  parameter int FRAME_W = 16,
  parameter int REPEAT = 16,
  parameter logic [FRAME_W-1:0] INIT_WORD = 16'h817E,
  parameter logic [FRAME_W-1:0] SEQ_INIT = 16'hF0F0,
  parameter logic [FRAME_W-1:0] IDLE_WORD = 16'hAAAA,
  parameter int CNT_W = 16
) (
  input  logic               clksend,
  input  logic               rstin,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [FRAME_W-1:0] word_in,
  input  logic               word_valid,
  output logic               word_ready,
  output logic               serial_out,
  output logic               frame_start,
  output logic [CNT_W-1:0]   frame_count,
  output logic               underrun
);
`ifdef TTC_GEN_PARITY_EN
  localparam int LEN = FRAME_W + 1;
`else
  localparam int LEN = FRAME_W;
`endif
  localparam int BW = $clog2(LEN + 1);
  localparam int RW = $clog2(REPEAT + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] rep_cnt;
  logic [FRAME_W-1:0] seq, word, shreg, next_word;
  logic frame_end, new_word, seq_step;
  // frame_end is the edge at which the last bit of the frame is on serial_out
  assign frame_end = state == RUN && bit_cnt == BW'(LEN - 1);
  assign new_word = rep_cnt == RW'(REPEAT - 1);
  assign word_ready = frame_end && enable && new_word && mode == 2'd1;
  assign seq_step = new_word && mode != 2'd1 && mode != 2'd2;
  always_comb
    next_word = !new_word ? word :
                mode == 2'd2 ? {word[FRAME_W-2:0], word[FRAME_W-1]} :
                mode == 2'd1 ? (word_valid ? word_in : IDLE_WORD) : seq;
  always_ff @(posedge clksend or posedge rstin) begin
    if (rstin) begin
      state <= IDLE;
      serial_out <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
      frame_count <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      seq <= SEQ_INIT;
      word <= INIT_WORD;
      shreg <= '0;
    end else begin
      frame_start <= 1'b0;
      underrun <= 1'b0;
      if (state == IDLE) begin
        serial_out <= 1'b0;
        if (enable) begin
          state <= RUN;
          serial_out <= INIT_WORD[FRAME_W-1];
          frame_start <= 1'b1;
          shreg <= INIT_WORD << 1;
          word <= INIT_WORD;
          bit_cnt <= '0;
          rep_cnt <= '0;
          frame_count <= frame_count + 1'b1;
        end
      end else if (frame_end) begin
        bit_cnt <= '0;
        if (!enable) begin
          state <= IDLE;
          serial_out <= 1'b0;
        end else begin
          frame_start <= 1'b1;
          frame_count <= frame_count + 1'b1;
          rep_cnt <= new_word ? '0 : rep_cnt + 1'b1;
          word <= next_word;
          serial_out <= next_word[FRAME_W-1];
          shreg <= next_word << 1;
          seq <= seq_step ? seq + 1'b1 : seq;
          underrun <= word_ready & ~word_valid;
        end
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        shreg <= shreg << 1;
`ifdef TTC_GEN_PARITY_EN
        // after the last data bit the even-parity bit of the frame's word follows
        serial_out <= bit_cnt == BW'(FRAME_W - 1) ? ^word : shreg[FRAME_W-1];
`else
        serial_out <= shreg[FRAME_W-1];
`endif
      end
    end
  end
endmodule

// File: tb/tb_ttc_stream_gen.sv
// tb_ttc_stream_gen: scoreboard bench for ttc_stream_gen with a frame-level reference model
module tb_ttc_stream_gen;
`ifdef TTC_GEN_PARITY_EN
  localparam int LEN = 17;
`else
  localparam int LEN = 16;
`endif
  localparam int REPEAT = 16;
  logic clksend, rstin, enable, word_valid, word_ready, serial_out, frame_start, underrun;
  logic [1:0] mode;
  logic [15:0] word_in, frame_count;
  ttc_stream_gen dut (
    .clksend(clksend), .rstin(rstin), .enable(enable), .mode(mode),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .serial_out(serial_out), .frame_start(frame_start),
    .frame_count(frame_count), .underrun(underrun)
  );
  typedef struct {
    logic [15:0] word;
    logic [15:0] cnt;
    logic und;
  } frame_t;
  frame_t exp_q[$];
  bit rdy_q[$];
  int tests = 0, fails = 0;
  logic [15:0] m_seq = 16'hF0F0, m_cnt = 16'h0000, m_word;
  initial clksend = 1'b0;
  always #5 clksend = ~clksend;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [LEN-1:0] frame_bits(logic [15:0] w);
`ifdef TTC_GEN_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction
  task automatic push_frame(logic [15:0] w, logic und);
    frame_t f;
    m_cnt = m_cnt + 16'd1;
    f.word = w;
    f.cnt = m_cnt;
    f.und = und;
    exp_q.push_back(f);
  endtask
  // one enable session of n frames; inputs are changed at bit 5 of every frame and
  // the last frame drops enable, so the stream must stop cleanly afterwards
  task automatic run(int n, int md, bit vld, logic [15:0] win, bit rnd);
    logic [15:0] nw;
    bit und;
    m_word = 16'h817E;
    push_frame(m_word, 1'b0);
    @(negedge clksend);
    enable = 1'b1;
    repeat (5) @(negedge clksend);
    for (int k = 1; k <= n; k++) begin
      @(negedge clksend);
      if (rnd) begin
        md = $urandom_range(0, 3);
        vld = 1'($urandom_range(0, 1));
        win = 16'($urandom);
      end
      mode = 2'(md);
      word_valid = vld;
      word_in = win;
      if (k == n) begin
        enable = 1'b0;
        rdy_q.push_back(1'b0);
      end else begin
        und = 1'b0;
        nw = m_word;
        if (k % REPEAT == 0) begin
          if (md == 2) nw = {m_word[14:0], m_word[15]};
          else if (md == 1) begin
            nw = vld ? win : 16'hAAAA;
            und = !vld;
          end else begin
            nw = m_seq;
            m_seq = m_seq + 16'd1;
          end
        end
        rdy_q.push_back(k % REPEAT == 0 && md == 1);
        m_word = nw;
        push_frame(nw, und);
      end
      if (k < n) repeat (LEN - 1) @(negedge clksend);
    end
    repeat (LEN - 5) @(negedge clksend);
    for (int i = 0; i < 4; i++) begin
      check("idle_serial", serial_out, 0);
      check("idle_frame_start", frame_start, 0);
      @(negedge clksend);
    end
  endtask
  initial begin : monitor
    frame_t e;
    logic [LEN-1:0] bits;
    logic [15:0] fc;
    logic un;
    bit abort;
    forever begin
      @(negedge clksend);
      if (frame_start && !rstin) begin
        if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
        else begin
          e = exp_q.pop_front();
          bits = LEN'(serial_out);
          fc = frame_count;
          un = underrun;
          abort = 0;
          check("ready_bit0", word_ready, 0);
          for (int i = 1; i < LEN; i++) begin
            @(negedge clksend);
            if (rstin) begin
              abort = 1;
              break;
            end
            bits = (bits << 1) | LEN'(serial_out);
            if (i == LEN - 1) begin
              if (rdy_q.size() == 0) check("ready_queue_empty", 1, 0);
              else check("word_ready_end", word_ready, 32'(rdy_q.pop_front()));
            end else begin
              check("word_ready_mid", word_ready, 0);
              check("underrun_mid", underrun, 0);
            end
          end
          if (!abort) begin
            check("frame_bits", 32'(bits), 32'(frame_bits(e.word)));
            check("frame_count", fc, e.cnt);
            check("underrun", un, e.und);
          end
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rstin = 1'b1;
    enable = 1'b0;
    mode = 2'd0;
    word_in = 16'h0;
    word_valid = 1'b0;
    #1;
    check("rst_serial", serial_out, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_word_ready", word_ready, 0);
    check("rst_underrun", underrun, 0);
    check("rst_frame_count", frame_count, 0);
    repeat (3) @(negedge clksend);
    rstin = 1'b0;
    run(34, 0, 1'b0, 16'h0, 1'b0);
    run(33, 1, 1'b1, 16'h1234, 1'b0);
    run(33, 1, 1'b0, 16'h5555, 1'b0);
    run(49, 2, 1'b0, 16'h0, 1'b0);
    run(80, 0, 1'b0, 16'h0, 1'b1);
    // reset in the middle of a frame
    m_word = 16'h817E;
    push_frame(m_word, 1'b0);
    @(negedge clksend);
    enable = 1'b1;
    mode = 2'd0;
    repeat (8) @(negedge clksend);
    rstin = 1'b1;
    #1;
    check("midrst_serial", serial_out, 0);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_frame_start", frame_start, 0);
    enable = 1'b0;
    repeat (3) @(negedge clksend);
    exp_q.delete();
    rdy_q.delete();
    m_seq = 16'hF0F0;
    m_cnt = 16'h0000;
    rstin = 1'b0;
    run(18, 0, 1'b0, 16'h0, 1'b0);
    repeat (5) @(negedge clksend);
    check("frames_outstanding", exp_q.size(), 0);
    check("ready_outstanding", rdy_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
